// File: rtl/gb_seq_pkg.sv
// rtl/gb_seq_pkg.sv - shared types and constants for the gbprocessor opcode sequencer
package gb_seq_pkg;

  typedef logic [7:0] opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESULT,
    S_HALTED
  } seq_state_t;

  localparam opcode_t OPC_NOP  = 8'h00;
  localparam opcode_t OPC_HALT = 8'h76;

endpackage

// File: rtl/gb_instr_fifo.sv
// rtl/gb_instr_fifo.sv - synchronous opcode FIFO with full/empty flags, no bypass
module gb_instr_fifo
  import gb_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    i_push,
  input  opcode_t i_data,
  input  logic    i_pop,
  output opcode_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  opcode_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Advance read/write pointers; reset empties the queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/gb_instr_sequencer.sv
// rtl/gb_instr_sequencer.sv - issues queued opcodes to gbprocessor and returns probe results
module gb_instr_sequencer
  import gb_seq_pkg::*;
#(
  parameter int      DEPTH       = 8,
  parameter int      LATENCY     = 2,
  parameter opcode_t HALT_OPCODE = OPC_HALT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  gb_instruction,
  output logic        gb_valid,
  input  logic [7:0]  gb_probe,
  output logic [7:0]  res_opcode,
  output logic [7:0]  res_data,
  output logic        res_valid,
  input  logic        res_ready,
  input  logic        resume,
  output logic        halted,
  output logic [15:0] issue_count
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  opcode_t          r_issued_op;
  opcode_t          r_res_opcode;
  opcode_t          r_res_data;
  logic [15:0]      r_issue_count;

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  opcode_t w_head;

  // No pass-through at full: a pop in the same cycle does not open the port.
  assign in_ready = !w_full && !reset;
  assign w_push   = in_valid && in_ready;
  // ISSUE is only entered with a non-empty FIFO, so the pop always succeeds.
  assign w_pop    = (r_state == S_ISSUE);

  gb_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (in_instr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Issue/wait/result sequencing, WAIT countdown, result capture and issue counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_issued_op   <= OPC_NOP;
      r_res_opcode  <= OPC_NOP;
      r_res_data    <= '0;
      r_issue_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_issued_op   <= w_head;
          r_issue_count <= r_issue_count + 16'd1;
          if (w_head == HALT_OPCODE) begin
            r_state <= S_HALTED;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Last WAIT cycle is T+LATENCY; probe is captured on its closing edge.
          if (r_cnt == CNT_ONE) begin
            r_res_data   <= gb_probe;
            r_res_opcode <= r_issued_op;
            r_state      <= S_RESULT;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_RESULT: begin
          if (res_ready) r_state <= w_empty ? S_IDLE : S_ISSUE;
        end
        S_HALTED: begin
          if (resume) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; reset forces every output low at once.
  assign gb_valid       = !reset && (r_state == S_ISSUE);
  assign gb_instruction = gb_valid ? w_head : OPC_NOP;
  assign res_valid      = !reset && (r_state == S_RESULT);
  assign res_opcode     = reset ? OPC_NOP : r_res_opcode;
  assign res_data       = reset ? 8'h00 : r_res_data;
  assign halted         = !reset && (r_state == S_HALTED);
  assign issue_count    = reset ? 16'h0000 : r_issue_count;

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// tb/tb_gb_instr_sequencer.sv - self-checking bench for gb_instr_sequencer
module tb_gb_instr_sequencer;
  import gb_seq_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  gb_instruction;
  logic        gb_valid;
  logic [7:0]  gb_probe;
  logic [7:0]  res_opcode;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        resume;
  logic        halted;
  logic [15:0] issue_count;

  always #5 clock = ~clock;

  gb_instr_sequencer #(
    .DEPTH       (DEPTH),
    .LATENCY     (LATENCY),
    .HALT_OPCODE (8'h76)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_instr       (in_instr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .gb_instruction (gb_instruction),
    .gb_valid       (gb_valid),
    .gb_probe       (gb_probe),
    .res_opcode     (res_opcode),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .resume         (resume),
    .halted         (halted),
    .issue_count    (issue_count)
  );

  typedef struct { logic [7:0] op; int cyc; } iss_t;
  typedef struct { logic [7:0] op; logic [7:0] data; int first; } res_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] probe_hist [0:4095];
  bit         probe_rand;
  logic [7:0] probe_fixed;

  logic [7:0] acc_q [$];
  iss_t       iss_q [$];
  res_t       res_q [$];
  res_t       exp_q [$];
  bit         res_pend;
  int         res_first;
  logic [7:0] res_op0, res_d0;
  int         stab_err;

  logic        s_in_ready, s_gb_valid, s_res_valid, s_halted;
  logic [7:0]  s_gb_instr, s_res_op, s_res_data;
  logic [15:0] s_count;

  function automatic logic [7:0] probe_at(int c);
    logic [11:0] k;
    k = 12'(c);
    return probe_hist[k];
  endfunction

  task automatic clear_model();
    acc_q.delete(); iss_q.delete(); res_q.delete(); exp_q.delete();
    res_pend = 0; stab_err = 0;
  endtask

  // Reference model: the i-th accepted opcode is the i-th issued; every non-HALT
  // opcode returns the probe seen LATENCY cycles after its issue, one cycle later.
  task automatic build_expected();
    exp_q.delete();
    for (int j = 0; j < acc_q.size() && j < iss_q.size(); j++) begin
      if (acc_q[j] != 8'h76)
        exp_q.push_back('{op: acc_q[j], data: probe_at(iss_q[j].cyc + LATENCY),
                          first: iss_q[j].cyc + LATENCY + 1});
    end
  endtask

  // One clock: sample/record at negedge, then advance and drive a new probe value.
  task automatic cycle_io();
    @(negedge clock);
    s_in_ready = in_ready;  s_gb_valid = gb_valid;   s_gb_instr = gb_instruction;
    s_res_valid = res_valid; s_res_op = res_opcode;  s_res_data = res_data;
    s_halted = halted;       s_count = issue_count;
    if (in_valid && s_in_ready) acc_q.push_back(in_instr);
    if (s_gb_valid) iss_q.push_back('{op: s_gb_instr, cyc: cyc});
    if (s_res_valid) begin
      if (!res_pend) begin
        res_pend = 1; res_first = cyc; res_op0 = s_res_op; res_d0 = s_res_data;
      end else if (s_res_op !== res_op0 || s_res_data !== res_d0) begin
        stab_err++;
      end
      if (res_ready) begin
        res_q.push_back('{op: res_op0, data: res_d0, first: res_first});
        res_pend = 0;
      end
    end else if (res_pend) begin
      stab_err++;
      res_pend = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    gb_probe = probe_rand ? 8'($urandom) : probe_fixed;
    probe_hist[12'(cyc)] = gb_probe;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle_io();
  endtask

  task automatic do_reset();
    reset = 1'b1; run(2); reset = 1'b0; clear_model();
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    reset = 1'b1;
    run(3);
    outs = {s_in_ready, s_gb_valid, s_res_valid, s_halted, s_gb_instr, s_res_op, s_res_data, s_count};
    n_vec++; if (outs !== '0) begin n_err++; $display("FAIL reset_por_outputs got %h want 0", outs); end
    reset = 1'b0;
    cycle_io();
    n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b want 1", s_in_ready); end
    clear_model();
    in_valid = 1'b1; in_instr = 8'h11;
    cycle_io();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && iss_q.size() == 0; i++) cycle_io();
    n_vec++; if (iss_q.size() != 1) begin n_err++; $display("FAIL reset_issue_timeout got %0d issues want 1", iss_q.size()); end
    // Now in the first WAIT cycle: hold reset for two cycles.
    clear_model();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle_io();
      outs = {s_in_ready, s_gb_valid, s_res_valid, s_halted, s_gb_instr, s_res_op, s_res_data, s_count};
      n_vec++; if (outs !== '0) begin n_err++; $display("FAIL reset_midwait_outputs got %h want 0", outs); end
    end
    reset = 1'b0;
    clear_model();
    cycle_io();
    n_vec++; if ({s_in_ready, s_count} !== {1'b1, 16'h0}) begin
      n_err++; $display("FAIL reset_release got ready=%b count=%0d want ready=1 count=0", s_in_ready, s_count);
    end
    run(10);
    n_vec++; if (res_q.size() != 0 || res_pend || iss_q.size() != 0) begin
      n_err++; $display("FAIL reset_abandon got results=%0d pend=%0d issues=%0d want 0", res_q.size(), res_pend, iss_q.size());
    end
  endtask

  task automatic test_single();
    int p;
    clear_model();
    probe_rand = 0; probe_fixed = 8'h5A; res_ready = 1'b1;
    gb_probe = 8'h5A; probe_hist[12'(cyc)] = 8'h5A;
    p = cyc;
    in_valid = 1'b1; in_instr = 8'h80;
    cycle_io();
    in_valid = 1'b0;
    run(15);
    n_vec++; if (iss_q.size() != 1) begin n_err++; $display("FAIL single_issue_count got %0d want 1", iss_q.size()); end
    if (iss_q.size() == 1) begin
      n_vec++; if (iss_q[0].cyc != p + 2 || iss_q[0].op !== 8'h80) begin
        n_err++; $display("FAIL single_issue got op=%h at +%0d want op=80 at +2", iss_q[0].op, iss_q[0].cyc - p);
      end
    end
    n_vec++; if (res_q.size() != 1) begin n_err++; $display("FAIL single_result_count got %0d want 1", res_q.size()); end
    if (res_q.size() == 1) begin
      n_vec++; if (res_q[0].op !== 8'h80 || res_q[0].data !== 8'h5A || res_q[0].first != p + 5) begin
        n_err++; $display("FAIL single_result got op=%h data=%h at +%0d want op=80 data=5a at +5",
                          res_q[0].op, res_q[0].data, res_q[0].first - p);
      end
    end
    probe_rand = 1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [3];
    ops = '{8'h3C, 8'h04, 8'h05};
    clear_model();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = ops[i]; cycle_io();
    end
    in_valid = 1'b0;
    run(25);
    build_expected();
    n_vec++; if (iss_q.size() != 3 || res_q.size() != 3) begin
      n_err++; $display("FAIL b2b_counts got issues=%0d results=%0d want 3/3", iss_q.size(), res_q.size());
    end
    for (int i = 0; i < iss_q.size() && i < 3; i++) begin
      n_vec++; if (iss_q[i].op !== ops[i]) begin n_err++; $display("FAIL b2b_issue_op[%0d] got %h want %h", i, iss_q[i].op, ops[i]); end
      if (i > 0) begin
        n_vec++; if (iss_q[i].cyc - iss_q[i-1].cyc != LATENCY + 2) begin
          n_err++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i, iss_q[i].cyc - iss_q[i-1].cyc, LATENCY + 2);
        end
      end
    end
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (res_q[i] != exp_q[i]) begin
        n_err++; $display("FAIL b2b_result[%0d] got %h/%h@%0d want %h/%h@%0d", i, res_q[i].op, res_q[i].data,
                          res_q[i].first, exp_q[i].op, exp_q[i].data, exp_q[i].first);
      end
    end
  endtask

  task automatic test_full();
    bit chk_done;
    clear_model();
    res_ready = 1'b0; chk_done = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = (acc_q.size() < 10); in_instr = 8'(acc_q.size() + 1);
      cycle_io();
    end
    n_vec++; if (acc_q.size() != 9 || s_in_ready !== 1'b0 || iss_q.size() != 1) begin
      n_err++; $display("FAIL full_accept got acc=%0d ready=%b issues=%0d want 9/0/1", acc_q.size(), s_in_ready, iss_q.size());
    end
    res_ready = 1'b1;
    for (int i = 0; i < 100 && res_q.size() < 10; i++) begin
      in_valid = (acc_q.size() < 10); in_instr = 8'(acc_q.size() + 1);
      cycle_io();
      if (iss_q.size() == 2 && !chk_done) begin
        chk_done = 1;
        n_vec++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_passthru got ready=%b want 0", s_in_ready); end
      end
    end
    in_valid = 1'b0;
    build_expected();
    n_vec++; if (res_q.size() != 10) begin n_err++; $display("FAIL full_drain got %0d results want 10", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (res_q[i].op !== 8'(i + 1) || res_q[i] != exp_q[i]) begin
        n_err++; $display("FAIL full_result[%0d] got %h/%h@%0d want %h/%h@%0d", i, res_q[i].op, res_q[i].data,
                          res_q[i].first, 8'(i + 1), exp_q[i].data, exp_q[i].first);
      end
    end
    n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL full_hold got %0d instabilities want 0", stab_err); end
  endtask

  task automatic test_halt();
    logic [7:0] ops [3];
    int r;
    ops = '{8'h3C, 8'h76, 8'h04};
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = ops[i]; cycle_io();
    end
    in_valid = 1'b0;
    run(25);
    n_vec++; if (iss_q.size() != 2 || res_q.size() != 1 || s_halted !== 1'b1 || s_count !== 16'd2) begin
      n_err++; $display("FAIL halt_enter got issues=%0d results=%0d halted=%b count=%0d want 2/1/1/2",
                        iss_q.size(), res_q.size(), s_halted, s_count);
    end
    if (iss_q.size() >= 2) begin
      n_vec++; if (iss_q[1].op !== 8'h76) begin n_err++; $display("FAIL halt_issued got %h want 76", iss_q[1].op); end
    end
    r = cyc;
    resume = 1'b1; cycle_io(); resume = 1'b0;
    run(15);
    build_expected();
    n_vec++; if (iss_q.size() != 3 || s_count !== 16'd3 || s_halted !== 1'b0) begin
      n_err++; $display("FAIL halt_resume got issues=%0d count=%0d halted=%b want 3/3/0", iss_q.size(), s_count, s_halted);
    end
    if (iss_q.size() == 3) begin
      n_vec++; if (iss_q[2].op !== 8'h04 || iss_q[2].cyc != r + 2) begin
        n_err++; $display("FAIL halt_resume_issue got %h at +%0d want 04 at +2", iss_q[2].op, iss_q[2].cyc - r);
      end
    end
    n_vec++; if (res_q.size() != 2) begin n_err++; $display("FAIL halt_results got %0d want 2", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (res_q[i] != exp_q[i]) begin
        n_err++; $display("FAIL halt_result[%0d] got %h/%h want %h/%h", i, res_q[i].op, res_q[i].data, exp_q[i].op, exp_q[i].data);
      end
    end
  endtask

  task automatic test_resume_ignored();
    clear_model();
    res_ready = 1'b1;
    resume = 1'b1; cycle_io(); resume = 1'b0;
    run(3);
    n_vec++; if (s_halted !== 1'b0 || iss_q.size() != 0) begin
      n_err++; $display("FAIL resume_idle got halted=%b issues=%0d want 0/0", s_halted, iss_q.size());
    end
    res_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (acc_q.size() < 12); in_instr = 8'(8'h20 + acc_q.size());
      cycle_io();
    end
    resume = 1'b1; in_instr = 8'hEE; cycle_io(); resume = 1'b0;
    run(2);
    n_vec++; if (s_res_valid !== 1'b1 || s_halted !== 1'b0 || acc_q.size() != 9) begin
      n_err++; $display("FAIL resume_result got valid=%b halted=%b acc=%0d want 1/0/9", s_res_valid, s_halted, acc_q.size());
    end
    res_ready = 1'b1;
    for (int i = 0; i < 150 && res_q.size() < 12; i++) begin
      in_valid = (acc_q.size() < 12); in_instr = 8'(8'h20 + acc_q.size());
      cycle_io();
    end
    in_valid = 1'b0;
    build_expected();
    n_vec++; if (res_q.size() != 12) begin n_err++; $display("FAIL resume_drain got %0d results want 12", res_q.size()); end
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (res_q[i].op !== 8'(8'h20 + i) || res_q[i] != exp_q[i]) begin
        n_err++; $display("FAIL resume_result[%0d] got %h/%h want %h/%h", i, res_q[i].op, res_q[i].data, 8'(8'h20 + i), exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_instr  = 8'($urandom);
      if (in_instr == 8'h76) in_instr = 8'h77;
      res_ready = ($urandom_range(0, 3) != 0);
      resume    = ($urandom_range(0, 15) == 0);
      cycle_io();
    end
    in_valid = 1'b0; resume = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 200 && res_q.size() < acc_q.size(); i++) cycle_io();
    run(2);
    build_expected();
    n_vec++; if (res_q.size() != acc_q.size() || iss_q.size() != acc_q.size()) begin
      n_err++; $display("FAIL rand_counts got acc=%0d issues=%0d results=%0d", acc_q.size(), iss_q.size(), res_q.size());
    end
    for (int i = 0; i < iss_q.size() && i < acc_q.size(); i++) begin
      n_vec++; if (iss_q[i].op !== acc_q[i]) begin n_err++; $display("FAIL rand_issue[%0d] got %h want %h", i, iss_q[i].op, acc_q[i]); end
    end
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (res_q[i] != exp_q[i]) begin
        n_err++; $display("FAIL rand_result[%0d] got %h/%h@%0d want %h/%h@%0d", i, res_q[i].op, res_q[i].data,
                          res_q[i].first, exp_q[i].op, exp_q[i].data, exp_q[i].first);
      end
    end
    n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL rand_hold got %0d instabilities want 0", stab_err); end
  endtask

  initial begin
    reset = 1'b1; in_instr = 8'h00; in_valid = 1'b0; res_ready = 1'b1; resume = 1'b0;
    probe_rand = 1; probe_fixed = 8'h00; gb_probe = 8'h00; probe_hist[0] = 8'h00;
    res_pend = 0; stab_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_halt();
    test_resume_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
